// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: accepts calculator ops, drives the ALU operands and returns registered flagged results
module calc_op_sequencer #(
    parameter int W = 11
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] IN_A,
    input  logic [W-1:0] IN_B,
    input  logic [2:0]   IN_OP,
    input  logic         IN_CHAIN,
    output logic [W:0]   ALU_A,
    output logic [W:0]   ALU_B,
    output logic [2:0]   ALU_CTRL,
    input  logic [W:0]   ALU_RESULT,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] OUT_RESULT,
    output logic         OUT_ZERO,
    output logic         OUT_NEG,
    output logic         OUT_OVF,
    output logic         OUT_ERR
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [W:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]     alu_ctrl_q, alu_ctrl_d;
    logic [W-1:0]   acc_q, acc_d, res_q, res_d;
    logic           err_q, err_d, arith_q, arith_d;
    logic           valid_q, valid_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, oerr_q, oerr_d;
    logic [W-1:0]   src_a, issue_res;
    logic           legal, issue_ovf;

    assign src_a     = IN_CHAIN ? acc_q : IN_A;
    assign legal     = (IN_OP != 3'b000) && (IN_OP <= 3'b101);
    assign issue_res = err_q ? '0 : ALU_RESULT[W-1:0];
    assign issue_ovf = arith_q & (ALU_RESULT[W] ^ ALU_RESULT[W-1]);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        acc_d      = acc_q;
        err_d      = err_q;
        arith_d    = arith_q;
        valid_d    = valid_q;
        res_d      = res_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        oerr_d     = oerr_q;
        unique case (state_q)
            IDLE: if (IN_VALID) begin
                alu_a_d    = {src_a[W-1], src_a};
                alu_b_d    = {IN_B[W-1], IN_B};
                alu_ctrl_d = legal ? IN_OP : 3'b101;
                err_d      = !legal;
                arith_d    = (IN_OP == 3'b001) || (IN_OP == 3'b010);
                state_d    = ISSUE;
            end
            ISSUE: begin
                res_d   = issue_res;
                zero_d  = issue_res == '0;
                neg_d   = issue_res[W-1];
                ovf_d   = issue_ovf;
                oerr_d  = err_q;
                valid_d = 1'b1;
                acc_d   = (!err_q && !issue_ovf) ? ALU_RESULT[W-1:0] : acc_q;
                state_d = HOLD;
            end
            HOLD: if (OUT_READY) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= 3'b000;
            acc_q      <= '0;
            err_q      <= 1'b0;
            arith_q    <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            arith_q    <= arith_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            oerr_q     <= oerr_d;
        end
    end

    assign IN_READY   = (state_q == IDLE) && !RST;
    assign ALU_A      = alu_a_q;
    assign ALU_B      = alu_b_q;
    assign ALU_CTRL   = alu_ctrl_q;
    assign OUT_VALID  = valid_q;
    assign OUT_RESULT = res_q;
    assign OUT_ZERO   = zero_q;
    assign OUT_NEG    = neg_q;
    assign OUT_OVF    = ovf_q;
    assign OUT_ERR    = oerr_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed vectors against calc_op_sequencer with a behavioural ALU attached
module tb_calc_op_sequencer;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        IN_VALID = 1'b0, IN_CHAIN = 1'b0, OUT_READY = 1'b0;
    logic        IN_READY, OUT_VALID, OUT_ZERO, OUT_NEG, OUT_OVF, OUT_ERR;
    logic [10:0] IN_A = '0, IN_B = '0, OUT_RESULT;
    logic [2:0]  IN_OP = '0, ALU_CTRL;
    logic [11:0] ALU_A, ALU_B, ALU_RESULT;
    int          nvec = 0, nerr = 0;

    calc_op_sequencer #(.W(11)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .IN_OP(IN_OP), .IN_CHAIN(IN_CHAIN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CTRL(ALU_CTRL), .ALU_RESULT(ALU_RESULT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
        .OUT_ZERO(OUT_ZERO), .OUT_NEG(OUT_NEG), .OUT_OVF(OUT_OVF), .OUT_ERR(OUT_ERR)
    );

    always #5 CLK = ~CLK;

    assign ALU_RESULT = (ALU_CTRL == 3'b001) ? ALU_A + ALU_B :
                        (ALU_CTRL == 3'b010) ? ALU_A - ALU_B :
                        (ALU_CTRL == 3'b011) ? ALU_A & ALU_B :
                        (ALU_CTRL == 3'b100) ? ALU_A | ALU_B :
                        (ALU_CTRL == 3'b101) ? ALU_A : 12'h000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [10:0] a, input logic [10:0] b, input logic [2:0] op, input logic ch);
        int n = 0;
        while (!IN_READY && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        chk("ready_before_issue", 32'(IN_READY), 32'd1);
        IN_A = a; IN_B = b; IN_OP = op; IN_CHAIN = ch; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 1;
        while (!OUT_VALID && n < 10) begin
            @(posedge CLK); #1; n++;
        end
        chk(tag, n, 2);
    endtask

    task automatic result(input string tag, input logic [10:0] r, input logic [3:0] f);
        chk(tag, {17'd0, OUT_RESULT, OUT_ZERO, OUT_NEG, OUT_OVF, OUT_ERR}, {17'd0, r, f});
    endtask

    task automatic take();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        chk("valid_drop", 32'(OUT_VALID), 32'd0);
    endtask

    task automatic run(input string tag, input logic [10:0] a, input logic [10:0] b,
                       input logic [2:0] op, input logic ch, input logic [10:0] r, input logic [3:0] f);
        issue(a, b, op, ch);
        wait_out({tag, "_lat"});
        result(tag, r, f);
        take();
    endtask

    initial begin
        logic [31:0] held;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(IN_READY), 32'd0);
        chk("rst_outs", {25'd0, OUT_VALID, OUT_ZERO, OUT_NEG, OUT_OVF, OUT_ERR, ALU_CTRL}, 32'd0);
        chk("rst_alu_ab", {8'd0, ALU_A, ALU_B}, 32'd0);
        chk("rst_res", 32'(OUT_RESULT), 32'd0);
        RST = 1'b0;
        #1;
        chk("idle_ready", 32'(IN_READY), 32'd1);

        issue(11'd300, 11'd200, 3'b001, 1'b0);
        chk("add_alu_a", 32'(ALU_A), 32'h12C);
        chk("add_ready_busy", 32'(IN_READY), 32'd0);
        wait_out("add_lat");
        result("add", 11'd500, 4'b0000);
        take();

        run("chain_sub", 11'd123, 11'd500, 3'b010, 1'b1, 11'd0, 4'b1000);
        issue(11'd77, 11'd3, 3'b111, 1'b0);
        chk("err_ctrl", 32'(ALU_CTRL), 32'd5);
        wait_out("err_lat");
        result("err", 11'd0, 4'b1001);
        take();
        run("acc_after_err", 11'd9, 11'd0, 3'b101, 1'b1, 11'd0, 4'b1000);

        issue(11'd5, 11'd9, 3'b010, 1'b0);
        chk("sub_ctrl", 32'(ALU_CTRL), 32'd2);
        chk("sub_alu_b", 32'(ALU_B), 32'h009);
        wait_out("sub_lat");
        result("sub", 11'h7FC, 4'b0100);
        take();

        run("ovf_add", 11'd1000, 11'd100, 3'b001, 1'b0, 11'h44C, 4'b0110);
        issue(11'h400, 11'd1, 3'b010, 1'b0);
        chk("ovf_sub_alu_a", 32'(ALU_A), 32'hC00);
        wait_out("ovf_sub_lat");
        result("ovf_sub", 11'h3FF, 4'b0010);
        take();
        run("acc_after_ovf", 11'd0, 11'd0, 3'b101, 1'b1, 11'h7FC, 4'b0100);
        run("and", 11'h0F3, 11'h03C, 3'b011, 1'b0, 11'h030, 4'b0000);
        run("or", 11'h700, 11'h00F, 3'b100, 1'b0, 11'h70F, 4'b0100);

        issue(11'd1, 11'd2, 3'b001, 1'b0);
        wait_out("bp_lat");
        IN_A = 11'd50; IN_B = 11'd60; IN_OP = 3'b011; IN_CHAIN = 1'b0; IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            result("bp_hold", 11'd3, 4'b0000);
            chk("bp_ready", {30'd0, IN_READY, OUT_VALID}, 32'd1);
            chk("bp_alu", {8'd0, ALU_A, ALU_B}, {8'd0, 12'd1, 12'd2});
        end
        IN_VALID = 1'b0;
        take();
        chk("bp_ready_after", 32'(IN_READY), 32'd1);
        result("bp_keep", 11'd3, 4'b0000);
        @(posedge CLK); #1;
        chk("bp_no_accept", 32'(IN_READY), 32'd1);

        issue(11'd20, 11'd30, 3'b001, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(IN_READY), 32'd1);
        chk("mid_rst_outs", {29'd0, OUT_VALID, ALU_CTRL}, 32'd0);
        held = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            held = held | 32'(OUT_VALID);
        end
        chk("mid_rst_no_out", held, 32'd0);
        run("acc_after_rst", 11'd44, 11'd0, 3'b101, 1'b1, 11'd0, 4'b1000);
        run("post_rst_add", 11'd7, 11'd8, 3'b001, 1'b0, 11'd15, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Front-end sequencer for the 11-bit signed calculator datapath, sitting directly upstream of the ALU.
- Accepts an operation request (two 11-bit two's-complement operands and an opcode) over a valid/ready handshake, sign-extends the operands and registers them onto the ALU inputs.
- Captures the ALU's 12-bit RESULT and returns a registered 11-bit result with its own zero/negative/overflow/error flags.
- Holds an accumulator so that chained operations can reuse the previous result as operand A.

Parameters:
- W, 11, operand/result width presented to the user (ALU side is W+1).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  sequencer can accept a request.
- IN_A  in  W  operand A, two's complement.
- IN_B  in  W  operand B, two's complement.
- IN_OP  in  3  001 add, 010 sub, 011 and, 100 or, 101 pass A; others illegal.
- IN_CHAIN  in  1  1 = use accumulator in place of IN_A.
- ALU_A  out  W+1  registered, sign-extended operand A to ALU.
- ALU_B  out  W+1  registered, sign-extended operand B to ALU.
- ALU_CTRL  out  3  registered opcode to ALU.
- ALU_RESULT  in  W+1  combinational result from ALU.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- OUT_RESULT  out  W  result.
- OUT_ZERO  out  1  OUT_RESULT == 0.
- OUT_NEG  out  1  OUT_RESULT[W-1].
- OUT_OVF  out  1  signed overflow on add/sub.
- OUT_ERR  out  1  illegal opcode.

Behaviour:
- Reset state: RST=1 at an edge forces IDLE and clears the following to 0:
  - ALU_A, ALU_B, ALU_CTRL (3'b000), ACC
  - OUT_VALID, OUT_RESULT, OUT_ZERO, OUT_NEG, OUT_OVF, OUT_ERR
  - RST overrides any in-flight or pending operation; the op is discarded and no result is produced.
- States: IDLE -> ISSUE -> HOLD -> IDLE.
- IN_READY = (state == IDLE) and RST == 0. It is combinational from state only and does not depend on IN_VALID.
- IDLE, when IN_VALID & IN_READY (accept edge):
  - ALU_A <= sign-extend(IN_CHAIN ? ACC : IN_A).
  - ALU_B <= sign-extend(IN_B).
  - ALU_CTRL <= legal IN_OP ? IN_OP : 3'b101.
  - Latch err = illegal op, and is_arith = op in {001, 010}.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle, lets the ALU settle). At the next edge:
  - OUT_RESULT <= err ? 0 : ALU_RESULT[W-1:0].
  - OUT_OVF <= is_arith & (ALU_RESULT[W] != ALU_RESULT[W-1]).
  - OUT_ERR <= err.
  - OUT_ZERO and OUT_NEG are derived from the value being loaded into OUT_RESULT.
  - OUT_VALID <= 1.
  - ACC <= ALU_RESULT[W-1:0] only if !err & !ovf; otherwise ACC is unchanged.
  - Go to HOLD.
- Latency: OUT_VALID rises 2 edges after the accept edge. Peak throughput is 1 op per 3 cycles.
- HOLD:
  - All OUT_* are stable while OUT_VALID=1 & OUT_READY=0, for an unbounded number of cycles.
  - On OUT_VALID & OUT_READY: OUT_VALID <= 0, go to IDLE. OUT_RESULT and the flags keep their values.
  - A new request is accepted no earlier than the edge after the output handshake.
- ALU_A, ALU_B and ALU_CTRL hold their values outside the accept edge.
- OUT_READY is ignored outside HOLD.
- IN_* are ignored outside IDLE; there is no buffering.
- Chaining: ACC is the last non-error, non-overflow result. IN_CHAIN=1 after reset uses 0.
- Overflow on add/sub: OUT_RESULT is the wrapped 11-bit value (no saturation).
- AND, OR and pass never set OUT_OVF.

Test Plan:
- Add: IN_A=300, IN_B=200, IN_OP=001 -> OUT_VALID 2 cycles after accept; OUT_RESULT=500, ZERO=0, NEG=0, OVF=0; ALU_A=12'h12C.
- Subtract: IN_A=5, IN_B=9, IN_OP=010 -> OUT_RESULT=11'h7FC (-4), NEG=1, OVF=0; ALU_CTRL=010 during ISSUE.
- Overflow: IN_A=1000, IN_B=100, add -> OUT_OVF=1, OUT_RESULT=11'h44C (-948), ACC unchanged; then IN_A=-1024, IN_B=1, sub -> OVF=1.
- Chain: 300+200, then IN_CHAIN=1, IN_B=500, IN_OP=010, with IN_A=123 ignored -> OUT_RESULT=0, ZERO=1; then IN_OP=111 -> ERR=1, RESULT=0, ACC still 0.
- Backpressure: OUT_READY low for 5 cycles -> OUT_* stable, IN_READY=0, a second IN_VALID is not accepted; OUT_READY high -> IN_READY=1 on the next cycle.
- Reset mid-op: RST asserted in ISSUE -> next cycle IDLE, OUT_VALID=0, ACC=0, ALU_CTRL=000; no result emitted; next request completes normally.
